// File: rtl/lfsr_rng_stream_if.sv
// Sample stream carried from lfsr_rng_stream to its consumer.
// The master drives data and valid; the slave drives ready.
interface lfsr_rng_stream_if #(
  parameter int unsigned OUT_W = 4
);
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/lfsr_rng_stream.sv
// Galois LFSR random source with warm-up discard, seed load, zero-lockup recovery and a valid/ready sample stream.
// Optional macro RNG_LEAP_EN: each warm-up cycle and each sample advances the LFSR LEAP steps instead of one.
module lfsr_rng_stream #(
  parameter int unsigned      WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(16'h0001),
  parameter int unsigned      OUT_W        = 4,
  parameter int unsigned      WARMUP       = 8,
  parameter int unsigned      CNT_W        = 16,
  parameter int unsigned      LEAP         = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                seed_load,
  input  logic [WIDTH-1:0]    seed,
  lfsr_rng_stream_if.master   stream,
  output logic [WIDTH-1:0]    state_out,
  output logic                lockup,
  output logic [CNT_W-1:0]    sample_count
);

`ifdef RNG_LEAP_EN
  localparam int unsigned STEPS = LEAP;
`else
  // Single step per advance; LEAP has no effect in this build.
  localparam int unsigned STEPS = 1 + 0 * LEAP;
`endif
  localparam int unsigned WCNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  typedef enum logic [0:0] {S_WARMUP = 1'b0, S_RUN = 1'b1} fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [WIDTH-1:0]  lfsr_q, lfsr_d;
  logic [OUT_W-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              lockup_q, lockup_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              accept_c;
  logic              running_c;
  logic [WIDTH-1:0]  stepped_c;

  // STEPS applications of the Galois step, unrolled into one combinational cone.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    r = s;
    for (int unsigned i = 0; i < STEPS; i++) begin
      r = (r >> 1) ^ (r[0] ? TAPS : '0);
    end
    return r;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q    <= S_WARMUP;
      wcnt_q   <= '0;
      lfsr_q   <= DEFAULT_SEED;
      data_q   <= '0;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
      count_q  <= '0;
    end else begin
      fsm_q    <= fsm_d;
      wcnt_q   <= wcnt_d;
      lfsr_q   <= lfsr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      lockup_q <= lockup_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    wcnt_d    = wcnt_q;
    lfsr_d    = lfsr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    lockup_d  = 1'b0;
    count_d   = count_q;
    accept_c  = valid_q && stream.out_ready;
    running_c = (fsm_q == S_RUN) || (WARMUP == 0);
    stepped_c = advance(lfsr_q);

    if (seed_load) begin
      // Seed load drops any pending sample and restarts warm-up; no handshake is counted.
      valid_d = 1'b0;
      wcnt_d  = '0;
      fsm_d   = S_WARMUP;
      if (seed == '0) begin
        lfsr_d   = DEFAULT_SEED;
        lockup_d = 1'b1;
      end else begin
        lfsr_d = seed;
      end
    end else begin
      if (accept_c) begin
        count_d = count_q + CNT_W'(1);
        valid_d = 1'b0;
      end
      if (enable) begin
        if (lfsr_q == '0) begin
          lfsr_d   = DEFAULT_SEED;
          lockup_d = 1'b1;
        end else if (running_c) begin
          if (!valid_q || stream.out_ready) begin
            lfsr_d  = stepped_c;
            data_d  = stepped_c[OUT_W-1:0];
            valid_d = 1'b1;
          end
        end else begin
          lfsr_d = stepped_c;
          if (wcnt_q == WCNT_W'(WARMUP - 1)) begin
            fsm_d  = S_RUN;
            wcnt_d = '0;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end
    end
  end

  assign stream.out_data  = data_q;
  assign stream.out_valid = valid_q;
  assign state_out        = lfsr_q;
  assign lockup           = lockup_q;
  assign sample_count     = count_q;

endmodule
